// File: rtl/mixer_pkg.sv
// Shared types and constants for the time-multiplexed channel mixer family.
package mixer_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} mixer_state_t;

   typedef enum logic {MODE_SAT = 1'b0, MODE_SCALE = 1'b1} mixer_mode_t;

   // Right shift that normalises a full-scale sum of num_ch channels in SCALE mode.
   function automatic int unsigned scale_sh(input int unsigned num_ch);
      return $clog2(num_ch);
   endfunction

endpackage

// File: rtl/mixer_saturate.sv
// Combinational unsigned clip of an IN_W-bit value into OUT_W bits.
module mixer_saturate #(
   parameter int unsigned IN_W  = 12,
   parameter int unsigned OUT_W = 8
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   if (IN_W > OUT_W) begin : g_clip
      localparam logic [IN_W-1:0] MAX_VAL = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
      assign dout = (din > MAX_VAL) ? {OUT_W{1'b1}} : din[OUT_W-1:0];
   end else begin : g_pass
      assign dout = OUT_W'(din);
   end

endmodule

// File: rtl/signal_mixer_seq.sv
// Time-multiplexed channel mixer: snapshots all channels on a strobe, then adds one
// channel per clock and presents the clipped or scaled sum with a one-cycle valid pulse.
module signal_mixer_seq
   import mixer_pkg::*;
#(
   parameter int unsigned NUM_CH   = 12,
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned OUT_W    = 8,
   parameter int unsigned ACC_W    = SAMPLE_W + $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                sample_strobe,
   input  logic [SAMPLE_W-1:0] samples_in [NUM_CH],
   input  logic [NUM_CH-1:0]   sample_enable,
   input  logic [1:0]          atten [NUM_CH],
   input  logic                mode,
   output logic [OUT_W-1:0]    sample_out,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int unsigned IDX_W    = $clog2(NUM_CH);
   localparam int unsigned SCALE_SH = scale_sh(NUM_CH);

   mixer_state_t state_q, state_d;

   logic [IDX_W-1:0]    idx_q;
   logic [ACC_W-1:0]    acc_q;
   logic [SAMPLE_W-1:0] snap_sample [NUM_CH];
   logic [1:0]          snap_atten  [NUM_CH];
   logic [NUM_CH-1:0]   snap_enable;
   mixer_mode_t         snap_mode;

   logic                last_ch;
   logic [SAMPLE_W-1:0] chan_val;
   logic [ACC_W-1:0]    addend;
   logic [ACC_W-1:0]    mix_val;
   logic [OUT_W-1:0]    sat_val;

   assign busy     = (state_q != IDLE);
   assign last_ch  = (idx_q == IDX_W'(NUM_CH - 1));
   assign chan_val = snap_sample[idx_q] >> snap_atten[idx_q];
   assign addend   = snap_enable[idx_q] ? ACC_W'(chan_val) : '0;
   assign mix_val  = (snap_mode == MODE_SCALE) ? (acc_q >> SCALE_SH) : acc_q;

   mixer_saturate #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W)
   ) u_saturate (
      .din  (mix_val),
      .dout (sat_val)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_strobe) state_d = ACCUM;
         ACCUM:   if (last_ch) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         idx_q       <= '0;
         acc_q       <= '0;
         snap_enable <= '0;
         snap_mode   <= MODE_SAT;
         for (int i = 0; i < NUM_CH; i++) begin
            snap_sample[i] <= '0;
            snap_atten[i]  <= '0;
         end
         sample_out  <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         out_valid <= (state_q == DONE);
         // A strobe seen while busy (including the DONE cycle) is dropped.
         overrun   <= sample_strobe && busy;
         case (state_q)
            IDLE: begin
               if (sample_strobe) begin
                  snap_sample <= samples_in;
                  snap_atten  <= atten;
                  snap_enable <= sample_enable;
                  snap_mode   <= mixer_mode_t'(mode);
                  acc_q       <= '0;
                  idx_q       <= '0;
               end
            end
            ACCUM: begin
               acc_q <= acc_q + addend;
               idx_q <= idx_q + IDX_W'(1);
            end
            DONE: begin
               sample_out <= sat_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signal_mixer_seq.sv
// Randomised self-checking bench for signal_mixer_seq against an arithmetic reference mix.
module tb_signal_mixer_seq;

   localparam int NUM_CH   = 12;
   localparam int SAMPLE_W = 8;
   localparam int OUT_W    = 8;

   logic                clk = 1'b0;
   logic                nrst;
   logic                sample_strobe;
   logic [SAMPLE_W-1:0] samples_in [NUM_CH];
   logic [NUM_CH-1:0]   sample_enable;
   logic [1:0]          atten [NUM_CH];
   logic                mode;
   logic [OUT_W-1:0]    sample_out;
   logic                out_valid;
   logic                busy;
   logic                overrun;

   int total = 0;
   int bad   = 0;

   signal_mixer_seq #(
      .NUM_CH   (NUM_CH),
      .SAMPLE_W (SAMPLE_W),
      .OUT_W    (OUT_W)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .sample_strobe (sample_strobe),
      .samples_in    (samples_in),
      .sample_enable (sample_enable),
      .atten         (atten),
      .mode          (mode),
      .sample_out    (sample_out),
      .out_valid     (out_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Reference: sum of enabled attenuated samples, optional divide by 2^clog2(N), then clip.
   function automatic int model_mix();
      int sum = 0;
      for (int i = 0; i < NUM_CH; i++)
         if (sample_enable[i]) sum += int'(samples_in[i]) / (1 << atten[i]);
      if (mode) sum = sum / (1 << $clog2(NUM_CH));
      if (sum > (1 << OUT_W) - 1) sum = (1 << OUT_W) - 1;
      return sum;
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < NUM_CH; i++) begin
         samples_in[i] = SAMPLE_W'($urandom);
         atten[i]      = 2'($urandom);
      end
      sample_enable = NUM_CH'($urandom);
      mode          = 1'($urandom);
   endtask

   task automatic set_uniform(input int val, input int att, input int en, input int md);
      for (int i = 0; i < NUM_CH; i++) begin
         samples_in[i] = SAMPLE_W'(val);
         atten[i]      = 2'(att);
      end
      sample_enable = NUM_CH'(en);
      mode          = 1'(md);
   endtask

   // Caller sets inputs and raises sample_strobe at a negedge; returns at the negedge
   // where out_valid is seen. poke_kind 1 re-strobes, 2 scrambles inputs, at cycle poke_at.
   task automatic run_mix(input int poke_at, input int poke_kind, output int lat,
                          output int res, output int busy_cnt, output int ov_cnt,
                          output bit timeout, output logic busy_at_valid);
      lat = 0; res = -1; busy_cnt = 0; ov_cnt = 0; timeout = 1'b1; busy_at_valid = 1'bx;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sample_strobe = 1'b0;
         if (overrun) ov_cnt++;
         if (out_valid) begin
            timeout = 1'b0;
            res = int'(sample_out);
            busy_at_valid = busy;
            break;
         end
         if (busy) busy_cnt++;
         if (lat == poke_at && poke_kind == 1) sample_strobe = 1'b1;
         if (lat == poke_at && poke_kind == 2) rand_inputs();
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #2;
      total += 4;
      if (sample_out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", sample_out); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_sat_overflow();
      int lat, res, bcnt, ocnt; bit to; logic bav;
      set_uniform(255, 0, 12'hFFF, 0);
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total += 5;
      if (to) begin bad++; $display("FAIL sat_timeout got=timeout want=out_valid"); end
      if (lat !== 13) begin bad++; $display("FAIL sat_latency got=%0d want=13", lat); end
      if (res !== 255) begin bad++; $display("FAIL sat_value got=%0d want=255", res); end
      if (bcnt !== 13) begin bad++; $display("FAIL sat_busy_cycles got=%0d want=13", bcnt); end
      if (bav !== 1'b0) begin bad++; $display("FAIL sat_busy_at_valid got=%b want=0", bav); end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL sat_valid_pulse got=%b want=0", out_valid); end
   endtask

   task automatic test_no_overflow();
      int lat, res, bcnt, ocnt; bit to; logic bav;
      for (int i = 0; i < NUM_CH; i++) begin
         samples_in[i] = SAMPLE_W'(10 * (i + 1));
         atten[i] = 2'd0;
      end
      sample_enable = 12'b0000_0001_0101;
      mode = 1'b0;
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total++;
      if (res !== 90) begin bad++; $display("FAIL no_overflow got=%0d want=90", res); end
   endtask

   task automatic test_atten_scale();
      int lat, res, bcnt, ocnt; bit to; logic bav;
      set_uniform(200, 1, 12'hFFF, 1);
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total++;
      if (res !== 75) begin bad++; $display("FAIL atten_scale got=%0d want=75", res); end
   endtask

   task automatic test_reset_mid_mix();
      int lat, res, bcnt, ocnt, vseen, exp; bit to; logic bav;
      set_uniform(255, 0, 12'hFFF, 0);
      @(negedge clk);
      sample_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sample_strobe = 1'b0;
      repeat (5) @(posedge clk);
      #1 nrst = 1'b0;
      #1;
      total += 3;
      if (sample_out !== 8'd0) begin bad++; $display("FAIL midrst_out got=%0d want=0", sample_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      vseen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) vseen++;
      end
      total++;
      if (vseen !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", vseen); end
      rand_inputs();
      exp = model_mix();
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total++;
      if (res !== exp) begin bad++; $display("FAIL midrst_fresh got=%0d want=%0d", res, exp); end
   endtask

   task automatic test_overrun();
      int lat, res, bcnt, ocnt, exp; bit to; logic bav;
      rand_inputs();
      exp = model_mix();
      @(negedge clk);
      sample_strobe = 1'b1;
      run_mix(2, 1, lat, res, bcnt, ocnt, to, bav);
      total += 3;
      if (ocnt !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d want=1", ocnt); end
      if (res !== exp) begin bad++; $display("FAIL overrun_result got=%0d want=%0d", res, exp); end
      if (lat !== 13) begin bad++; $display("FAIL overrun_latency got=%0d want=13", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, res, bcnt, ocnt, exp; bit to; logic bav;
      rand_inputs();
      exp = model_mix();
      @(negedge clk);
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total++;
      if (res !== exp) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", res, exp); end
      for (int k = 0; k < 3; k++) begin
         rand_inputs();
         exp = model_mix();
         sample_strobe = 1'b1;
         run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
         total += 3;
         if (lat !== 13) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=13", k, lat); end
         if (res !== exp) begin bad++; $display("FAIL b2b_value[%0d] got=%0d want=%0d", k, res, exp); end
         if (ocnt !== 0) begin bad++; $display("FAIL b2b_overrun[%0d] got=%0d want=0", k, ocnt); end
      end
   endtask

   task automatic test_snapshot_empty();
      int lat, res, bcnt, ocnt, exp; bit to; logic bav;
      rand_inputs();
      sample_enable = 12'hFFF;
      exp = model_mix();
      @(negedge clk);
      sample_strobe = 1'b1;
      run_mix(4, 2, lat, res, bcnt, ocnt, to, bav);
      total++;
      if (res !== exp) begin bad++; $display("FAIL snapshot got=%0d want=%0d", res, exp); end
      rand_inputs();
      sample_enable = '0;
      @(negedge clk);
      sample_strobe = 1'b1;
      run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
      total += 2;
      if (to) begin bad++; $display("FAIL empty_valid got=timeout want=out_valid"); end
      if (res !== 0) begin bad++; $display("FAIL empty_value got=%0d want=0", res); end
   endtask

   task automatic test_random();
      int lat, res, bcnt, ocnt, exp; bit to; logic bav;
      for (int k = 0; k < 20; k++) begin
         rand_inputs();
         exp = model_mix();
         @(negedge clk);
         sample_strobe = 1'b1;
         run_mix(-1, 0, lat, res, bcnt, ocnt, to, bav);
         total++;
         if (res !== exp) begin
            bad++;
            $display("FAIL random[%0d] got=%0d want=%0d mode=%b en=%h", k, res, exp, mode,
                     sample_enable);
         end
      end
   endtask

   initial begin
      nrst = 1'b0;
      sample_strobe = 1'b0;
      set_uniform(0, 0, 0, 0);
      test_reset();
      @(negedge clk);
      sample_strobe = 1'b0;
      test_sat_overflow();
      test_reset_mid_mix();
      @(negedge clk);
      test_no_overflow();
      @(negedge clk);
      test_atten_scale();
      test_overrun();
      test_back_to_back();
      test_snapshot_empty();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
